// File: rtl/pipe_stage_buf.sv
`default_nettype none
// =====================================================================
// Module  : pipe_stage_buf
// Brief   : valid/ready pipeline stage with optional skid entry,
//           flush-to-bubble and a saturating back-pressure counter.
// Revision: 1.0
// =====================================================================
module pipe_stage_buf #(
  parameter int DATA_W  = 64,
  parameter int TRACE_W = 0,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic                                     flush_i,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_W-1:0]                        in_data,
  input  logic [((TRACE_W > 0) ? TRACE_W : 1)-1:0] in_trace,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_W-1:0]                        out_data,
  output logic [((TRACE_W > 0) ? TRACE_W : 1)-1:0] out_trace,
  output logic [1:0]                               occupancy,
  output logic [CNT_W-1:0]                         stall_cnt,
  input  logic                                     stall_clr
);

  localparam int   c_TW       = (TRACE_W > 0) ? TRACE_W : 1;
  localparam logic c_TRACE_EN = (TRACE_W > 0);

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [c_TW-1:0]   r_m_trace;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [c_TW-1:0]   r_s_trace;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [c_TW-1:0]   w_in_trace;

  // With no trace path the sideband is masked to zero so it folds away.
  assign w_in_trace = in_trace & {c_TW{c_TRACE_EN}};
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_m_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !r_s_valid && !flush_i;

      always_ff @(posedge ACLK) begin
        if (ARESET || flush_i) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_trace <= '0;
          r_s_valid <= 1'b0;
          r_s_data  <= '0;
          r_s_trace <= '0;
        end else if (w_out_fire) begin
          if (r_s_valid) begin
            // in_ready is low while S is full, so no input can collide here
            r_m_valid <= 1'b1;
            r_m_data  <= r_s_data;
            r_m_trace <= r_s_trace;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_trace <= '0;
          end else if (w_in_fire) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
            r_m_trace <= w_in_trace;
          end else begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_trace <= '0;
          end
        end else if (w_in_fire) begin
          if (r_m_valid) begin
            r_s_valid <= 1'b1;
            r_s_data  <= in_data;
            r_s_trace <= w_in_trace;
          end else begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
            r_m_trace <= w_in_trace;
          end
        end
      end
    end else begin : g_noskid
      assign in_ready = (!r_m_valid || out_ready) && !flush_i;

      always_ff @(posedge ACLK) begin
        if (ARESET || flush_i) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_trace <= '0;
        end else if (w_in_fire) begin
          r_m_valid <= 1'b1;
          r_m_data  <= in_data;
          r_m_trace <= w_in_trace;
        end else if (w_out_fire) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_trace <= '0;
        end
      end

      always_ff @(posedge ACLK) begin
        r_s_valid <= 1'b0;
        r_s_data  <= '0;
        r_s_trace <= '0;
      end
    end
  endgenerate

  // Flush deliberately leaves the counter alone.
  always_ff @(posedge ACLK) begin
    if (ARESET || stall_clr) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_trace = r_m_trace;
  assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// =====================================================================
// Module  : tb_pipe_stage_buf
// Brief   : directed self-checking bench for pipe_stage_buf (SKID=1 and SKID=0).
// Revision: 1.0
// =====================================================================
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [63:0] a_in_data, a_out_data;
  logic [7:0]  a_in_trace, a_out_trace;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [31:0] b_in_data, b_out_data;
  logic [0:0]  b_in_trace, b_out_trace;
  logic [1:0]  b_occ;
  logic [2:0]  b_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  pipe_stage_buf #(.DATA_W(64), .TRACE_W(8), .SKID(1), .CNT_W(16)) u_dut_a (
    .ACLK(clk), .ARESET(rst), .flush_i(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_trace(a_in_trace),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_trace(a_out_trace),
    .occupancy(a_occ), .stall_cnt(a_cnt), .stall_clr(a_clr)
  );

  pipe_stage_buf #(.DATA_W(32), .TRACE_W(0), .SKID(0), .CNT_W(3)) u_dut_b (
    .ACLK(clk), .ARESET(rst), .flush_i(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_trace(b_in_trace),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_trace(b_out_trace),
    .occupancy(b_occ), .stall_cnt(b_cnt), .stall_clr(b_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_data = 64'hA5; a_in_trace = 8'h5A; a_out_ready = 1; a_clr = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 32'hA5; b_in_trace = 1'b1;  b_out_ready = 1; b_clr = 0;
    tick(); tick();
    check("a_rst_valid", a_out_valid, 0);
    check("a_rst_data",  a_out_data,  0);
    check("a_rst_trace", a_out_trace, 0);
    check("a_rst_occ",   a_occ,       0);
    check("a_rst_cnt",   a_cnt,       0);
    check("b_rst_valid", b_out_valid, 0);
    rst = 1'b0; a_in_valid = 0; b_in_valid = 0;
    #1;
    check("a_rst_ready", a_in_ready, 1);
    check("b_rst_ready", b_in_ready, 1);
    tick();
    check("a_post_rst_valid", a_out_valid, 0);

    // Streaming, SKID=1
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 64'(i); a_in_trace = 8'(i + 128);
      #1;
      check("a_stream_ready", a_in_ready, 1);
      tick();
      check("a_stream_valid", a_out_valid, 1);
      check("a_stream_data",  a_out_data,  64'(i));
      check("a_stream_trace", a_out_trace, 64'(i + 128));
    end
    a_in_valid = 0;
    tick();
    check("a_drain_valid", a_out_valid, 0);
    check("a_drain_data",  a_out_data,  0);

    // Back-pressure, SKID=1
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h10;
    tick();
    check("a_bp1_data",  a_out_data, 64'h10);
    check("a_bp1_occ",   a_occ,      1);
    check("a_bp1_ready", a_in_ready, 1);
    a_in_data = 64'h11;
    tick();
    check("a_bp2_occ",   a_occ,      2);
    check("a_bp2_ready", a_in_ready, 0);
    check("a_bp2_data",  a_out_data, 64'h10);
    check("a_bp2_cnt",   a_cnt,      1);
    a_in_data = 64'h12;
    tick();
    check("a_bp3_data",  a_out_data, 64'h10);
    check("a_bp3_occ",   a_occ,      2);
    check("a_bp3_cnt",   a_cnt,      2);
    check("a_bp3_ready", a_in_ready, 0);
    a_out_ready = 1;
    tick();
    check("a_bp4_data",  a_out_data, 64'h11);
    check("a_bp4_occ",   a_occ,      1);
    check("a_bp4_ready", a_in_ready, 1);
    tick();
    check("a_bp5_data",  a_out_data, 64'h12);
    check("a_bp5_occ",   a_occ,      1);
    a_in_valid = 0;
    tick();
    check("a_bp6_valid", a_out_valid, 0);
    check("a_bp6_cnt",   a_cnt,       2);

    // Flush with both entries full
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h30;
    tick();
    a_in_data = 64'h31;
    tick();
    check("a_fl_pre_occ", a_occ, 2);
    a_flush = 1; a_in_data = 64'h20; a_in_trace = 8'h55;
    #1;
    check("a_fl_ready", a_in_ready, 0);
    tick();
    check("a_fl_valid", a_out_valid, 0);
    check("a_fl_data",  a_out_data,  0);
    check("a_fl_trace", a_out_trace, 0);
    check("a_fl_occ",   a_occ,       0);
    check("a_fl_cnt",   a_cnt,       4);
    a_flush = 0; a_out_ready = 1;
    #1;
    check("a_resend_ready", a_in_ready, 1);
    tick();
    check("a_resend_valid", a_out_valid, 1);
    check("a_resend_data",  a_out_data,  64'h20);
    check("a_resend_trace", a_out_trace, 64'h55);

    // Flush with S empty still blocks input
    a_flush = 1; a_in_data = 64'h21;
    #1;
    check("a_fl2_ready", a_in_ready, 0);
    tick();
    check("a_fl2_valid", a_out_valid, 0);
    check("a_fl2_occ",   a_occ,       0);
    check("a_fl2_cnt",   a_cnt,       4);
    a_flush = 0; a_in_valid = 0; a_clr = 1;
    tick();
    check("a_clr_cnt", a_cnt, 0);
    a_clr = 0;

    // SKID=0 handshake
    b_out_ready = 1; b_in_valid = 1; b_in_data = 32'h100;
    #1;
    check("b_rdy_empty", b_in_ready, 1);
    tick();
    check("b_s1_valid", b_out_valid, 1);
    check("b_s1_data",  b_out_data,  32'h100);
    check("b_s1_trace", b_out_trace, 0);
    check("b_s1_occ",   b_occ,       1);
    b_out_ready = 0; b_in_data = 32'h101;
    #1;
    check("b_rdy_stall", b_in_ready, 0);
    tick();
    check("b_s2_data", b_out_data, 32'h100);
    check("b_s2_cnt",  b_cnt,      1);
    b_out_ready = 1;
    #1;
    check("b_rdy_resume", b_in_ready, 1);
    tick();
    check("b_s3_data", b_out_data, 32'h101);
    b_in_data = 32'h102;
    tick();
    check("b_s4_data", b_out_data, 32'h102);
    b_in_valid = 0;
    tick();
    check("b_s5_valid", b_out_valid, 0);
    check("b_s5_data",  b_out_data,  0);
    check("b_s5_occ",   b_occ,       0);

    // Saturating counter, CNT_W=3
    b_clr = 1;
    tick();
    check("b_clr0_cnt", b_cnt, 0);
    b_clr = 0; b_in_valid = 1; b_in_data = 32'h200; b_out_ready = 0;
    tick();
    check("b_load_cnt", b_cnt, 0);
    b_in_valid = 0;
    repeat (6) tick();
    check("b_cnt6", b_cnt, 6);
    repeat (4) tick();
    check("b_cnt_sat",  b_cnt,      7);
    check("b_sat_data", b_out_data, 32'h200);
    b_clr = 1;
    tick();
    check("b_clr_cnt", b_cnt, 0);
    b_clr = 0;
    tick();
    check("b_inc1_cnt", b_cnt, 1);
    tick();
    check("b_inc2_cnt", b_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
